// File: rtl/pe_seq_pkg.sv
// pe_seq_pkg: state encoding, count width and job helpers shared by
// pe_load_sequencer and its staging buffers.
package pe_seq_pkg;

  localparam int unsigned CNT_W = 8;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    BURST,
    GAP,
    START,
    WAIT,
    SUM,
    DONE
  } seq_state_t;

  // Number of output psums of a valid 1D convolution.
  function automatic cnt_t calc_nsums(input cnt_t wcount, input cnt_t acount);
    return acount - wcount + cnt_t'(1);
  endfunction

  // A job is legal when 1 <= wcount <= acount <= max_count.
  function automatic logic cfg_legal(input cnt_t wcount, input cnt_t acount,
                                     input int unsigned max_count);
    return (wcount != '0) && (wcount <= acount) && (32'(acount) <= max_count);
  endfunction

endpackage

// File: rtl/pe_seq_stage_buf.sv
// pe_seq_stage_buf: single-write-port staging buffer with an indexed
// combinational read, depth maxCount.
// Ports: clk; wr_en/wr_addr/wr_data write port; rd_addr/rd_data read port.
module pe_seq_stage_buf #(
  parameter int unsigned dataSize = 8,
  parameter int unsigned maxCount = 16,
  localparam int unsigned AW = (maxCount > 1) ? $clog2(maxCount) : 1
) (
  input  logic                clk,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [dataSize-1:0] wr_data,
  input  logic [AW-1:0]       rd_addr,
  output logic [dataSize-1:0] rd_data
);

  logic [dataSize-1:0] mem [maxCount];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pe_load_sequencer.sv
// pe_load_sequencer: stages a 1D-conv job's weights and activations, replays
// them into one PE as a single gap-free load burst, starts the PE, drives the
// systolic-sum phase and forwards the PE psums downstream.
// Ports: cmd_* job request; w_*/a_* input streams; psum_in_* neighbour psums;
// psum_out_* forwarded PE psums; pe_* PE data, controls and status;
// job_done / cfg_err one-cycle status pulses.
// Macro PE_SEQ_WREUSE_EN adds cmd_wreuse: keep the PE's resident weights.
module pe_load_sequencer
  import pe_seq_pkg::*;
#(
  parameter int unsigned dataSize = 8,
  parameter int unsigned maxCount = 16,
  localparam int unsigned macResSize = dataSize*2+4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [7:0]            cmd_wcount,
  input  logic [7:0]            cmd_acount,
  input  logic                  cmd_psum_zero,
`ifdef PE_SEQ_WREUSE_EN
  input  logic                  cmd_wreuse,
`endif
  input  logic                  w_valid,
  output logic                  w_ready,
  input  logic [dataSize-1:0]   w_data,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [dataSize-1:0]   a_data,
  input  logic                  psum_in_valid,
  output logic                  psum_in_ready,
  input  logic [macResSize-1:0] psum_in_data,
  output logic                  psum_out_valid,
  output logic [macResSize-1:0] psum_out_data,
  output logic [dataSize-1:0]   pe_weights,
  output logic [dataSize-1:0]   pe_acts,
  output logic [macResSize-1:0] pe_psum,
  output logic                  pe_loadw,
  output logic                  pe_loada,
  output logic                  pe_start,
  output logic                  pe_sums,
  input  logic                  pe_flag_done,
  input  logic                  pe_flag_psum_valid,
  input  logic [macResSize-1:0] pe_psum_o,
  output logic                  job_done,
  output logic                  cfg_err
);

  localparam int unsigned AW = (maxCount > 1) ? $clog2(maxCount) : 1;

  seq_state_t state, state_nxt;

  cnt_t wcount_q, acount_q, nsums_q;
  cnt_t w_cnt, a_cnt, k_cnt, sum_cnt;
  logic psum_zero_q, wreuse_q, cfg_err_q;
  logic cmd_fire, cmd_ok, w_fire, a_fire, w_full, a_full;
  logic [dataSize-1:0] w_rd, a_rd;

`ifdef PE_SEQ_WREUSE_EN
  cnt_t prev_wcount;
  logic prev_valid;

  // Reuse is only meaningful when the PE still holds weights of the same length.
  assign cmd_ok = cfg_legal(cmd_wcount, cmd_acount, maxCount) &&
                  (!cmd_wreuse || (prev_valid && (cmd_wcount == prev_wcount)));

  always_ff @(posedge clk) begin
    if (rst) begin
      wreuse_q    <= 1'b0;
      prev_valid  <= 1'b0;
      prev_wcount <= '0;
    end else if (cmd_fire && cmd_ok) begin
      wreuse_q    <= cmd_wreuse;
      prev_valid  <= 1'b1;
      prev_wcount <= cmd_wcount;
    end
  end
`else
  assign cmd_ok   = cfg_legal(cmd_wcount, cmd_acount, maxCount);
  assign wreuse_q = 1'b0;
`endif

  assign cmd_fire = (state == IDLE) && cmd_valid;
  assign w_ready  = (state == FILL) && !wreuse_q && (w_cnt < wcount_q);
  assign a_ready  = (state == FILL) && (a_cnt < acount_q);
  assign w_fire   = w_valid && w_ready;
  assign a_fire   = a_valid && a_ready;
  assign w_full   = wreuse_q || (w_cnt == wcount_q);
  assign a_full   = (a_cnt == acount_q);

  assign cfg_err        = cfg_err_q;
  assign psum_out_valid = pe_flag_psum_valid;
  assign psum_out_data  = pe_psum_o;

  pe_seq_stage_buf #(.dataSize(dataSize), .maxCount(maxCount)) u_wbuf (
    .clk     (clk),
    .wr_en   (w_fire),
    .wr_addr (w_cnt[AW-1:0]),
    .wr_data (w_data),
    .rd_addr (k_cnt[AW-1:0]),
    .rd_data (w_rd)
  );

  pe_seq_stage_buf #(.dataSize(dataSize), .maxCount(maxCount)) u_abuf (
    .clk     (clk),
    .wr_en   (a_fire),
    .wr_addr (a_cnt[AW-1:0]),
    .wr_data (a_data),
    .rd_addr (k_cnt[AW-1:0]),
    .rd_data (a_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    cmd_ready     = 1'b0;
    psum_in_ready = 1'b0;
    pe_weights    = '0;
    pe_acts       = '0;
    pe_psum       = '0;
    pe_loadw      = 1'b0;
    pe_loada      = 1'b0;
    pe_start      = 1'b0;
    pe_sums       = 1'b0;
    job_done      = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = !rst;
        if (cmd_fire && cmd_ok) state_nxt = FILL;
      end
      FILL: begin
        if (w_full && a_full) state_nxt = BURST;
      end
      BURST: begin
        // Both strobes rise together at k=0; loadw simply ends earlier.
        pe_loadw   = !wreuse_q && (k_cnt < wcount_q);
        pe_loada   = 1'b1;
        pe_weights = pe_loadw ? w_rd : '0;
        pe_acts    = a_rd;
        if (k_cnt == acount_q - cnt_t'(1)) state_nxt = GAP;
      end
      GAP:   state_nxt = START;
      START: begin
        pe_start  = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (pe_flag_done) state_nxt = SUM;
      end
      SUM: begin
        pe_sums       = psum_zero_q || psum_in_valid;
        psum_in_ready = !psum_zero_q && psum_in_valid;
        pe_psum       = psum_zero_q ? '0 : psum_in_data;
        if (pe_sums && (sum_cnt == nsums_q - cnt_t'(1))) state_nxt = DONE;
      end
      DONE: begin
        job_done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wcount_q    <= '0;
      acount_q    <= '0;
      nsums_q     <= '0;
      psum_zero_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      w_cnt       <= '0;
      a_cnt       <= '0;
      k_cnt       <= '0;
      sum_cnt     <= '0;
    end else begin
      cfg_err_q <= cmd_fire && !cmd_ok;
      if (cmd_fire && cmd_ok) begin
        wcount_q    <= cmd_wcount;
        acount_q    <= cmd_acount;
        nsums_q     <= calc_nsums(cmd_wcount, cmd_acount);
        psum_zero_q <= cmd_psum_zero;
        w_cnt       <= '0;
        a_cnt       <= '0;
        k_cnt       <= '0;
        sum_cnt     <= '0;
      end else begin
        if (w_fire) w_cnt <= w_cnt + cnt_t'(1);
        if (a_fire) a_cnt <= a_cnt + cnt_t'(1);
        if (state == BURST) k_cnt <= k_cnt + cnt_t'(1);
        if ((state == SUM) && pe_sums) sum_cnt <= sum_cnt + cnt_t'(1);
      end
    end
  end

endmodule

// File: tb/tb_pe_load_sequencer.sv
`timescale 1ns/1ps
module tb_pe_load_sequencer;

  localparam int unsigned DS = 8;
  localparam int unsigned MC = 16;
  localparam int unsigned MR = DS*2+4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, cmd_valid, cmd_ready, cmd_psum_zero, cmd_wreuse;
  logic [7:0]    cmd_wcount, cmd_acount;
  logic          w_valid, w_ready, a_valid, a_ready;
  logic [DS-1:0] w_data, a_data;
  logic          psum_in_valid, psum_in_ready, psum_out_valid;
  logic [MR-1:0] psum_in_data, psum_out_data, pe_psum, pe_psum_o;
  logic [DS-1:0] pe_weights, pe_acts;
  logic          pe_loadw, pe_loada, pe_start, pe_sums;
  logic          pe_flag_done, pe_flag_psum_valid, job_done, cfg_err;

  pe_load_sequencer #(.dataSize(DS), .maxCount(MC)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wcount(cmd_wcount),
    .cmd_acount(cmd_acount), .cmd_psum_zero(cmd_psum_zero),
`ifdef PE_SEQ_WREUSE_EN
    .cmd_wreuse(cmd_wreuse),
`endif
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .psum_in_valid(psum_in_valid), .psum_in_ready(psum_in_ready), .psum_in_data(psum_in_data),
    .psum_out_valid(psum_out_valid), .psum_out_data(psum_out_data),
    .pe_weights(pe_weights), .pe_acts(pe_acts), .pe_psum(pe_psum),
    .pe_loadw(pe_loadw), .pe_loada(pe_loada), .pe_start(pe_start), .pe_sums(pe_sums),
    .pe_flag_done(pe_flag_done), .pe_flag_psum_valid(pe_flag_psum_valid), .pe_psum_o(pe_psum_o),
    .job_done(job_done), .cfg_err(cfg_err)
  );

  // Behavioural PE: spad address resets whenever a load strobe is low.
  logic [DS-1:0] wmem [MC];
  logic [DS-1:0] amem [MC];
  int unsigned waddr, aaddr, wlen, sidx, done_tmr;

  function automatic logic [MR-1:0] conv(input int unsigned s);
    logic [MR-1:0] acc;
    acc = '0;
    for (int unsigned j = 0; j < wlen; j++) acc += MR'(wmem[j]) * MR'(amem[s+j]);
    return acc;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      waddr <= 0; aaddr <= 0; wlen <= 0; sidx <= 0; done_tmr <= 0;
      pe_flag_done <= 1'b0; pe_flag_psum_valid <= 1'b0; pe_psum_o <= '0;
    end else begin
      if (pe_loadw) begin
        wmem[waddr] <= pe_weights; waddr <= waddr + 1; wlen <= waddr + 1;
      end else waddr <= 0;
      if (pe_loada) begin
        amem[aaddr] <= pe_acts; aaddr <= aaddr + 1;
      end else aaddr <= 0;
      if (pe_start) begin
        done_tmr <= 4; sidx <= 0; pe_flag_done <= 1'b0;
      end else if (done_tmr > 0) begin
        done_tmr <= done_tmr - 1;
        if (done_tmr == 1) pe_flag_done <= 1'b1;
      end
      pe_flag_psum_valid <= pe_sums;
      if (pe_sums) begin
        pe_psum_o <= pe_psum + conv(sidx);
        sidx <= sidx + 1;
      end
    end
  end

  // Cumulative monitor; tasks diff snapshots around each job.
  int unsigned cyc, loadw_n, loada_n, loadw_rise, loada_rise, both_rise;
  int unsigned start_n, start_cyc, last_loada_cyc, done_n, err_n, wrdy_n, ardy_n, sums_n;
  logic prev_loadw, prev_loada;
  logic [MR-1:0] out_q[$];

  initial begin
    cyc = 0; loadw_n = 0; loada_n = 0; loadw_rise = 0; loada_rise = 0; both_rise = 0;
    start_n = 0; start_cyc = 0; last_loada_cyc = 0; done_n = 0; err_n = 0;
    wrdy_n = 0; ardy_n = 0; sums_n = 0; prev_loadw = 0; prev_loada = 0;
  end

  always @(negedge clk) begin
    cyc <= cyc + 1;
    prev_loadw <= pe_loadw;
    prev_loada <= pe_loada;
    if (pe_loadw) loadw_n <= loadw_n + 1;
    if (pe_loada) begin loada_n <= loada_n + 1; last_loada_cyc <= cyc; end
    if (pe_loadw && !prev_loadw) loadw_rise <= loadw_rise + 1;
    if (pe_loada && !prev_loada) loada_rise <= loada_rise + 1;
    if (pe_loadw && !prev_loadw && pe_loada && !prev_loada) both_rise <= both_rise + 1;
    if (pe_start) begin start_n <= start_n + 1; start_cyc <= cyc; end
    if (job_done) done_n <= done_n + 1;
    if (cfg_err) err_n <= err_n + 1;
    if (w_ready) wrdy_n <= wrdy_n + 1;
    if (a_ready) ardy_n <= ardy_n + 1;
    if (pe_sums) sums_n <= sums_n + 1;
    if (psum_out_valid) out_q.push_back(psum_out_data);
  end

  typedef struct {
    logic [7:0]    wcount, acount;
    logic          psum_zero, wreuse, rand_stall, exp_err;
    logic [DS-1:0] w [MC];
    logic [DS-1:0] a [MC];
    logic [MR-1:0] psum_in [4];
    int unsigned   gap [4];
    int unsigned   n_exp;
    logic [MR-1:0] exp_out [4];
  } vec_t;

  localparam int unsigned NV = 8;
  vec_t vec [NV];
  int checks = 0;
  int errors = 0;

  function automatic vec_t blank();
    vec_t v;
    v.wcount = '0; v.acount = '0; v.psum_zero = 1'b0; v.wreuse = 1'b0;
    v.rand_stall = 1'b0; v.exp_err = 1'b0; v.n_exp = 0;
    for (int unsigned i = 0; i < MC; i++) begin v.w[i] = '0; v.a[i] = '0; end
    for (int unsigned i = 0; i < 4; i++) begin v.psum_in[i] = '0; v.gap[i] = 0; v.exp_out[i] = '0; end
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic send_cmd(input vec_t v, input string nm);
    int unsigned t;
    t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
    chk({nm, ".cmd_ready_wait"}, 64'(t < 50), 64'd1);
    cmd_valid = 1'b1; cmd_wcount = v.wcount; cmd_acount = v.acount;
    cmd_psum_zero = v.psum_zero; cmd_wreuse = v.wreuse;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic feed_w(input vec_t v, input string nm);
    int unsigned idx, t;
    idx = 0; t = 0;
    if (!v.wreuse) begin
      while (idx < v.wcount && t < 300) begin
        @(negedge clk); t++;
        w_valid = v.rand_stall ? 1'($urandom_range(0, 1)) : 1'b1;
        w_data = v.w[idx];
        #1;
        if (w_valid && w_ready) idx++;
      end
      @(negedge clk); w_valid = 1'b0;
      chk({nm, ".w_accepted"}, 64'(idx), 64'(v.wcount));
    end
  endtask

  task automatic feed_a(input vec_t v, input string nm);
    int unsigned idx, t;
    idx = 0; t = 0;
    while (idx < v.acount && t < 300) begin
      @(negedge clk); t++;
      a_valid = v.rand_stall ? 1'($urandom_range(0, 1)) : 1'b1;
      a_data = v.a[idx];
      #1;
      if (a_valid && a_ready) idx++;
    end
    @(negedge clk); a_valid = 1'b0;
    chk({nm, ".a_accepted"}, 64'(idx), 64'(v.acount));
  endtask

  task automatic feed_psum(input vec_t v, input string nm);
    int unsigned idx, t;
    idx = 0; t = 0;
    if (!v.psum_zero) begin
      while (idx < v.n_exp && t < 400) begin
        repeat (v.gap[idx]) begin @(negedge clk); psum_in_valid = 1'b0; t++; end
        @(negedge clk); t++;
        psum_in_valid = 1'b1; psum_in_data = v.psum_in[idx];
        #1;
        if (psum_in_ready) idx++;
      end
      @(negedge clk); psum_in_valid = 1'b0;
      chk({nm, ".psum_accepted"}, 64'(idx), 64'(v.n_exp));
    end
  endtask

  task automatic run_job(input vec_t v, input string nm);
    int unsigned lw0, la0, lwr0, lar0, br0, st0, d0, e0, wr0, ar0, s0, o0, t;
    lw0 = loadw_n; la0 = loada_n; lwr0 = loadw_rise; lar0 = loada_rise; br0 = both_rise;
    st0 = start_n; d0 = done_n; e0 = err_n; wr0 = wrdy_n; ar0 = ardy_n; s0 = sums_n;
    o0 = out_q.size();
    send_cmd(v, nm);
    if (!v.exp_err) begin
      fork
        feed_w(v, nm);
        feed_a(v, nm);
        feed_psum(v, nm);
      join
    end
    t = 0;
    while (done_n == d0 && err_n == e0 && t < 300) begin @(negedge clk); t++; end
    repeat (4) @(negedge clk);
    chk({nm, ".cfg_err_pulses"}, 64'(err_n - e0), 64'(v.exp_err));
    chk({nm, ".job_done_pulses"}, 64'(done_n - d0), 64'(!v.exp_err));
    chk({nm, ".idle_cmd_ready"}, 64'(cmd_ready), 64'd1);
    if (v.exp_err || v.wreuse) chk({nm, ".w_ready_cycles"}, 64'(wrdy_n - wr0), 64'd0);
    if (v.exp_err) begin
      chk({nm, ".a_ready_cycles"}, 64'(ardy_n - ar0), 64'd0);
      chk({nm, ".start_pulses"}, 64'(start_n - st0), 64'd0);
    end else begin
      chk({nm, ".loadw_cycles"}, 64'(loadw_n - lw0), v.wreuse ? 64'd0 : 64'(v.wcount));
      chk({nm, ".loada_cycles"}, 64'(loada_n - la0), 64'(v.acount));
      chk({nm, ".loada_bursts"}, 64'(loada_rise - lar0), 64'd1);
      chk({nm, ".loadw_bursts"}, 64'(loadw_rise - lwr0), v.wreuse ? 64'd0 : 64'd1);
      chk({nm, ".strobes_aligned"}, 64'(both_rise - br0), v.wreuse ? 64'd0 : 64'd1);
      chk({nm, ".start_pulses"}, 64'(start_n - st0), 64'd1);
      chk({nm, ".load_to_start"}, 64'(start_cyc - last_loada_cyc), 64'd2);
      chk({nm, ".pe_sums_cycles"}, 64'(sums_n - s0), 64'(v.n_exp));
      chk({nm, ".psum_out_count"}, 64'(out_q.size() - o0), 64'(v.n_exp));
      for (int unsigned i = 0; i < v.n_exp; i++)
        if (o0 + i < out_q.size())
          chk($sformatf("%s.psum_out%0d", nm, i), 64'(out_q[o0+i]), 64'(v.exp_out[i]));
    end
  endtask

  task automatic chk_outputs_zero(input string nm);
    logic [127:0] outs;
    outs = {cmd_ready, w_ready, a_ready, psum_in_ready, psum_out_valid, psum_out_data,
            pe_weights, pe_acts, pe_psum, pe_loadw, pe_loada, pe_start, pe_sums,
            job_done, cfg_err};
    chk(nm, 64'($countones(outs)), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int unsigned t;
    rst = 1'b1; cmd_valid = 1'b0; cmd_wcount = '0; cmd_acount = '0;
    cmd_psum_zero = 1'b0; cmd_wreuse = 1'b0; w_valid = 1'b0; w_data = '0;
    a_valid = 1'b0; a_data = '0; psum_in_valid = 1'b0; psum_in_data = '0;

    v = blank();
    v.wcount = 3; v.acount = 5; v.psum_zero = 1'b1;
    for (int unsigned i = 0; i < 3; i++) v.w[i] = DS'(i + 1);
    for (int unsigned i = 0; i < 5; i++) v.a[i] = DS'(i + 1);
    v.n_exp = 3; v.exp_out[0] = 14; v.exp_out[1] = 20; v.exp_out[2] = 26;
    vec[0] = v;
    v.rand_stall = 1'b1; vec[1] = v;
    v.rand_stall = 1'b0; v.psum_zero = 1'b0;
    v.psum_in[0] = 100; v.psum_in[1] = 200; v.psum_in[2] = 300; v.gap[1] = 2;
    v.exp_out[0] = 114; v.exp_out[1] = 220; v.exp_out[2] = 326;
    vec[2] = v;
    v = blank(); v.wcount = 4; v.acount = 3; v.exp_err = 1'b1; vec[3] = v;
    v.wcount = 0; vec[4] = v;
    v = blank(); v.wcount = 16; v.acount = 16; v.psum_zero = 1'b1;
    for (int unsigned i = 0; i < 16; i++) begin v.w[i] = 1; v.a[i] = DS'(i + 1); end
    v.n_exp = 1; v.exp_out[0] = 136;
    vec[5] = v;
    v = blank(); v.wcount = 2; v.acount = 17; v.exp_err = 1'b1; vec[6] = v;
    v = blank(); v.wcount = 1; v.acount = 2; v.psum_zero = 1'b1;
    v.w[0] = 3; v.a[0] = 4; v.a[1] = 5;
    v.n_exp = 2; v.exp_out[0] = 12; v.exp_out[1] = 15;
    vec[7] = v;

    repeat (3) @(negedge clk);
    chk_outputs_zero("reset_outputs");
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_cmd_ready", 64'(cmd_ready), 64'd1);

    for (int unsigned i = 0; i < NV; i++) run_job(vec[i], $sformatf("vec%0d", i));

    // Abort a job in WAIT with reset, then run a fresh one.
    send_cmd(vec[0], "abort");
    fork
      feed_w(vec[0], "abort");
      feed_a(vec[0], "abort");
    join
    t = 0;
    while (!pe_start && t < 100) begin @(negedge clk); t++; end
    chk("abort.start_seen", 64'(pe_start), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_outputs_zero("abort.outputs_in_reset");
    rst = 1'b0;
    @(negedge clk);
    chk("abort.idle_after_reset", 64'(cmd_ready), 64'd1);

`ifdef PE_SEQ_WREUSE_EN
    v = vec[0]; v.wreuse = 1'b1; v.exp_err = 1'b1; v.n_exp = 0;
    run_job(v, "reuse_first_after_rst");
`endif
    run_job(vec[0], "post_abort");
`ifdef PE_SEQ_WREUSE_EN
    v = vec[0]; v.wreuse = 1'b1;
    for (int unsigned i = 0; i < 5; i++) v.a[i] = DS'(i + 2);
    v.exp_out[0] = 20; v.exp_out[1] = 26; v.exp_out[2] = 32;
    run_job(v, "reuse");
    v.wcount = 2; v.exp_err = 1'b1; v.n_exp = 0;
    run_job(v, "reuse_bad_wcount");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
